// File: rtl/sprite_draw_sequencer.sv
// Per-scanline sprite sequencer: fetches 4-pixel tile words and presents masked groups to the quadrupler.
// Define SPRITE_HFLIP_EN to add the spr_hflip input (reversed fetch order and byte order).
module sprite_draw_sequencer #(
  parameter int TILE_ADDR_W = 12,
  parameter int MEM_LATENCY = 2,
  parameter int LINE_SUBPX  = 1920
) (
  input  logic                   clk_draw,
  input  logic                   rst_draw_n,
  input  logic                   line_start,
  input  logic                   spr_valid,
  output logic                   spr_ready,
  input  logic [10:0]            spr_x,
  input  logic [3:0]             spr_groups,
  input  logic [TILE_ADDR_W-1:0] spr_addr,
  input  logic                   spr_last,
`ifdef SPRITE_HFLIP_EN
  input  logic                   spr_hflip,
`endif
  output logic                   mem_req,
  output logic [TILE_ADDR_W-1:0] mem_addr,
  input  logic [31:0]            mem_rdata,
  output logic [31:0]            tile_pixels,
  output logic [3:0]             tile_valid_mask,
  output logic [10:0]            tile_x,
  output logic                   busy,
  output logic                   line_done
);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, FLUSH} state_t;

  localparam logic [11:0] LINE_W = 12'(LINE_SUBPX);

  state_t                   state, nxt;
  logic [10:0]              x_q;
  logic [3:0]               groups_q;
  logic [3:0]               g_q;
  logic [TILE_ADDR_W-1:0]   addr_q;
  logic                     last_q;
  logic                     hflip_q;

  // Return tracking: one slot per cycle of memory latency, oldest at the top index.
  logic [MEM_LATENCY-1:0]       trk_vld;
  logic [MEM_LATENCY-1:0][11:0] trk_x;

  logic [11:0] grp_x;
  logic        on_line;
  logic        last_grp;
  logic        accept;
  logic        issue;
  logic [3:0]  fetch_idx;
  logic [31:0] ret_pix;
  logic [11:0] ret_x;
  logic [3:0]  ret_mask;
  logic        ret_vld;

  assign grp_x     = {1'b0, x_q} + {4'b0000, g_q, 4'b0000};
  assign on_line   = grp_x < LINE_W;
  assign last_grp  = (g_q == groups_q - 4'd1);
  assign spr_ready = rst_draw_n && (state == IDLE) && !line_start;
  assign accept    = spr_valid && spr_ready;
  assign fetch_idx = hflip_q ? (groups_q - 4'd1 - g_q) : g_q;
  assign mem_req   = issue;
  assign mem_addr  = issue ? (addr_q + TILE_ADDR_W'(fetch_idx)) : '0;
  assign busy      = (state != IDLE) || (|trk_vld);

  assign ret_vld = trk_vld[MEM_LATENCY-1] && !line_start;
  assign ret_x   = trk_x[MEM_LATENCY-1];
  assign ret_pix = hflip_q ? {mem_rdata[7:0], mem_rdata[15:8], mem_rdata[23:16], mem_rdata[31:24]}
                           : mem_rdata;

`ifndef SPRITE_HFLIP_EN
  assign hflip_q = 1'b0;
`endif

  always_comb begin
    ret_mask = '0;
    for (int i = 0; i < 4; i++) begin
      ret_mask[i] = (ret_pix[8*i +: 8] != 8'h00) && ((ret_x + 12'(4*i)) < LINE_W);
    end
  end

  always_comb begin
    nxt   = state;
    issue = 1'b0;
    case (state)
      IDLE:  if (accept) nxt = (spr_groups == 4'd0) ? FLUSH : FETCH;
      FETCH: begin
        if (!on_line) begin
          nxt = (g_q == 4'd0) ? FLUSH : DRAIN;
        end else begin
          issue = 1'b1;
          if (last_grp) nxt = DRAIN;
        end
      end
      DRAIN: if (!(|trk_vld)) nxt = FLUSH;
      FLUSH: nxt = IDLE;
      default: nxt = IDLE;
    endcase
    // A new scanline abandons whatever sprite is in progress.
    if (line_start) begin
      nxt   = IDLE;
      issue = 1'b0;
    end
  end

  always_ff @(posedge clk_draw) begin
    if (!rst_draw_n) begin
      state           <= IDLE;
      x_q             <= '0;
      groups_q        <= '0;
      g_q             <= '0;
      addr_q          <= '0;
      last_q          <= 1'b0;
`ifdef SPRITE_HFLIP_EN
      hflip_q         <= 1'b0;
`endif
      trk_vld         <= '0;
      trk_x           <= '0;
      tile_pixels     <= '0;
      tile_valid_mask <= '0;
      tile_x          <= '0;
      line_done       <= 1'b0;
    end else begin
      state <= nxt;
      if (accept) begin
        x_q      <= spr_x;
        groups_q <= spr_groups;
        addr_q   <= spr_addr;
        last_q   <= spr_last;
        g_q      <= '0;
`ifdef SPRITE_HFLIP_EN
        hflip_q  <= spr_hflip;
`endif
      end else if (issue) begin
        g_q <= g_q + 4'd1;
      end

      if (line_start) begin
        trk_vld <= '0;
      end else begin
        trk_vld[0] <= issue;
        trk_x[0]   <= grp_x;
        for (int i = 1; i < MEM_LATENCY; i++) begin
          trk_vld[i] <= trk_vld[i-1];
          trk_x[i]   <= trk_x[i-1];
        end
      end

      if (ret_vld) begin
        tile_pixels     <= ret_pix;
        tile_x          <= ret_x[10:0];
        tile_valid_mask <= ret_mask;
      end else begin
        tile_valid_mask <= '0;
      end

      line_done <= (state == FLUSH) && last_q && !line_start;
    end
  end

endmodule

// File: tb/tb_sprite_draw_sequencer.sv
// Bench for sprite_draw_sequencer: job table with tile/address scoreboards plus hand-written timing sequences.
`timescale 1ns/1ps
module tb_sprite_draw_sequencer;
  localparam int AW   = 12;
  localparam int LAT  = 2;
  localparam int LINE = 1920;

  logic          clk_draw = 1'b0;
  logic          rst_draw_n;
  logic          line_start;
  logic          spr_valid;
  logic          spr_ready;
  logic [10:0]   spr_x;
  logic [3:0]    spr_groups;
  logic [AW-1:0] spr_addr;
  logic          spr_last;
`ifdef SPRITE_HFLIP_EN
  logic          spr_hflip;
`endif
  logic          mem_req;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_rdata = 32'hA5A5A5A5;
  logic [31:0]   tile_pixels;
  logic [3:0]    tile_valid_mask;
  logic [10:0]   tile_x;
  logic          busy;
  logic          line_done;

  sprite_draw_sequencer #(.TILE_ADDR_W(AW), .MEM_LATENCY(LAT), .LINE_SUBPX(LINE)) dut (
    .clk_draw(clk_draw), .rst_draw_n(rst_draw_n), .line_start(line_start),
    .spr_valid(spr_valid), .spr_ready(spr_ready), .spr_x(spr_x), .spr_groups(spr_groups),
    .spr_addr(spr_addr), .spr_last(spr_last),
`ifdef SPRITE_HFLIP_EN
    .spr_hflip(spr_hflip),
`endif
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .tile_pixels(tile_pixels), .tile_valid_mask(tile_valid_mask), .tile_x(tile_x),
    .busy(busy), .line_done(line_done)
  );

  always #5 clk_draw = ~clk_draw;

  int cyc = 0;
  always @(posedge clk_draw) cyc++;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic note_fail(input string name, input logic [63:0] act);
    n_checks++;
    n_fail++;
    $display("FAIL %s: unexpected value %0h (cycle %0d)", name, act, cyc);
  endtask

  // Tile memory model with fixed read latency; data changes mid-cycle, away from the sampling edge.
  logic [31:0]   tmem [0:4095];
  logic [LAT-1:0] mp_vld = '0;
  logic [AW-1:0]  mp_addr [LAT];
  always @(negedge clk_draw) begin
    mem_rdata = mp_vld[LAT-1] ? tmem[mp_addr[LAT-1]] : 32'hA5A5A5A5;
    for (int k = LAT-1; k > 0; k--) begin
      mp_vld[k]  = mp_vld[k-1];
      mp_addr[k] = mp_addr[k-1];
    end
    mp_vld[0]  = mem_req;
    mp_addr[0] = mem_addr;
  end

  typedef struct {logic [10:0] x; logic [31:0] pix; logic [3:0] m;} tile_t;
  tile_t         exp_q [$];
  logic [AW-1:0] addr_q [$];
  int            out_cyc [$];
  logic [3:0]    out_m [$];
  int            req_cnt = 0;
  int            ld_cnt  = 0;
  bit            mon_en  = 1'b0;
  tile_t         mon_e;
  logic [AW-1:0] mon_a;

  always @(negedge clk_draw) begin
    if (mem_req)   req_cnt++;
    if (line_done) ld_cnt++;
    if (mon_en) begin
      if (mem_req) begin
        if (addr_q.size() == 0) note_fail("unexp_req", 64'(mem_addr));
        else begin
          mon_a = addr_q.pop_front();
          chk("mem_addr", 64'(mem_addr), 64'(mon_a));
        end
      end
      if (tile_valid_mask != 4'h0) begin
        out_cyc.push_back(cyc);
        out_m.push_back(tile_valid_mask);
        if (exp_q.size() == 0) note_fail("unexp_tile", 64'(tile_x));
        else begin
          mon_e = exp_q.pop_front();
          chk("tile_x", 64'(tile_x), 64'(mon_e.x));
          chk("tile_mask", 64'(tile_valid_mask), 64'(mon_e.m));
          chk("tile_pixels", 64'(tile_pixels), 64'(mon_e.pix));
        end
      end
    end
  end

  // Reference behaviour of one job: which words are fetched and what reaches the quadrupler.
  task automatic push_job(input int x, input int g, input int a);
    tile_t       t;
    int          gx;
    logic [31:0] w;
    for (int k = 0; k < g; k++) begin
      gx = x + 16*k;
      if (gx >= LINE) break;
      addr_q.push_back(AW'(a + k));
      w   = tmem[a + k];
      t.m = 4'h0;
      for (int i = 0; i < 4; i++)
        if (w[8*i +: 8] != 8'h00 && gx + 4*i < LINE) t.m[i] = 1'b1;
      t.x   = 11'(gx);
      t.pix = w;
      if (t.m != 4'h0) exp_q.push_back(t);
    end
  endtask

  task automatic drive_job(input int x, input int g, input int a, input logic last, input logic hf);
    int n = 0;
    @(negedge clk_draw);
    while (!spr_ready && n < 100) begin
      @(negedge clk_draw);
      n++;
    end
    if (n >= 100) note_fail("ready_timeout", 64'(spr_ready));
    spr_x      = 11'(x);
    spr_groups = 4'(g);
    spr_addr   = AW'(a);
    spr_last   = last;
`ifdef SPRITE_HFLIP_EN
    spr_hflip  = hf;
`else
    if (hf) $display("hflip request ignored in this build");
`endif
    spr_valid  = 1'b1;
    @(posedge clk_draw);
    #1 spr_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk_draw);
    while (busy && n < 300) begin
      @(negedge clk_draw);
      n++;
    end
    if (n >= 300) note_fail("idle_timeout", 64'(busy));
    @(negedge clk_draw);
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_mem_req"}, 64'(mem_req), 0);
    chk({tag, "_mem_addr"}, 64'(mem_addr), 0);
    chk({tag, "_pixels"}, 64'(tile_pixels), 0);
    chk({tag, "_mask"}, 64'(tile_valid_mask), 0);
    chk({tag, "_tile_x"}, 64'(tile_x), 0);
    chk({tag, "_ready"}, 64'(spr_ready), 0);
    chk({tag, "_busy"}, 64'(busy), 0);
    chk({tag, "_line_done"}, 64'(line_done), 0);
  endtask

  typedef struct {int x; int g; int a; bit last; int exp_req; int exp_done; logic [3:0] exp_m0;} vec_t;
  vec_t vecs [8];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int r0, d0, dmid, bad;
    logic [3:0]  em [7];
    logic [10:0] ex [7];
    logic        er [7];
    logic        ey [7];

    for (int i = 0; i < 4096; i++) begin
      logic [11:0] ai;
      ai = 12'(i);
      tmem[i] = {ai[7:0], 8'h00, ~ai[7:0], ai[11:4]};
    end
    tmem['h100] = 32'h04030201;  tmem['h101] = 32'h00080706;
    tmem['h200] = 32'h01020304;  tmem['h201] = 32'h05060708;  tmem['h202] = 32'h090A0B0C;
    tmem['h210] = 32'h11223344;
    tmem['h010] = 32'h0A0B0C0D;  tmem['h011] = 32'h04030201;

    //            x     g  addr   last req done mask0
    vecs[0] = '{  32,   2, 'h100, 0,   2,  0,   4'hF};
    vecs[1] = '{1904,   3, 'h200, 0,   1,  0,   4'hF};
    vecs[2] = '{1908,   1, 'h200, 0,   1,  0,   4'h7};
    vecs[3] = '{1912,   2, 'h210, 0,   1,  0,   4'h3};
    vecs[4] = '{   0,   0, 'h300, 1,   0,  1,   4'h0};
    vecs[5] = '{1920,   4, 'h300, 1,   0,  1,   4'h0};
    vecs[6] = '{ 100,  15, 'h400, 1,  15,  1,   4'h3};
    vecs[7] = '{1880,   5, 'h500, 0,   3,  0,   4'h3};

    rst_draw_n = 1'b0; line_start = 1'b0; spr_valid = 1'b0;
    spr_x = '0; spr_groups = '0; spr_addr = '0; spr_last = 1'b0;
`ifdef SPRITE_HFLIP_EN
    spr_hflip = 1'b0;
`endif
    repeat (3) @(posedge clk_draw);
    @(negedge clk_draw);
    chk_zero_outputs("por");
    rst_draw_n = 1'b1;
    @(negedge clk_draw);
    chk("por_release_ready", 64'(spr_ready), 1);

    // Reset held for three cycles in the middle of a fetch.
    drive_job(0, 8, 'h400, 1'b0, 1'b0);
    @(negedge clk_draw);
    chk("midfetch_req", 64'(mem_req), 1);
    rst_draw_n = 1'b0;
    repeat (3) @(posedge clk_draw);
    @(negedge clk_draw);
    chk_zero_outputs("rst");
    rst_draw_n = 1'b1;
    @(negedge clk_draw);
    chk("rst_release_ready", 64'(spr_ready), 1);
    chk("rst_release_busy", 64'(busy), 0);
    repeat (4) @(negedge clk_draw);

    // Cycle-exact single sprite: x=32, two groups.
    er = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    em = '{4'h0, 4'h0, 4'h0, 4'hF, 4'h7, 4'h0, 4'h0};
    ex = '{11'd0, 11'd0, 11'd0, 11'd32, 11'd48, 11'd0, 11'd0};
    ey = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    drive_job(32, 2, 'h100, 1'b0, 1'b0);
    for (int k = 0; k < 7; k++) begin
      @(negedge clk_draw);
      chk($sformatf("single_k%0d_req", k+1), 64'(mem_req), 64'(er[k]));
      if (k < 2) chk($sformatf("single_k%0d_addr", k+1), 64'(mem_addr), 64'('h100 + k));
      chk($sformatf("single_k%0d_mask", k+1), 64'(tile_valid_mask), 64'(em[k]));
      if (em[k] != 4'h0) chk($sformatf("single_k%0d_x", k+1), 64'(tile_x), 64'(ex[k]));
      if (k == 3) chk("single_pix0", 64'(tile_pixels), 64'h04030201);
      if (k == 4) chk("single_pix1", 64'(tile_pixels), 64'h00080706);
      chk($sformatf("single_k%0d_ready", k+1), 64'(spr_ready), 64'(ey[k]));
    end
    wait_idle();

    // Job table against the scoreboards.
    mon_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      r0 = req_cnt; d0 = ld_cnt;
      out_m.delete(); out_cyc.delete();
      push_job(vecs[i].x, vecs[i].g, vecs[i].a);
      drive_job(vecs[i].x, vecs[i].g, vecs[i].a, vecs[i].last, 1'b0);
      wait_idle();
      chk($sformatf("v%0d_nreq", i), 64'(req_cnt - r0), 64'(vecs[i].exp_req));
      chk($sformatf("v%0d_line_done", i), 64'(ld_cnt - d0), 64'(vecs[i].exp_done));
      chk($sformatf("v%0d_mask0", i), 64'(out_m.size() > 0 ? out_m[0] : 4'h0), 64'(vecs[i].exp_m0));
      chk($sformatf("v%0d_tiles_left", i), 64'(exp_q.size()), 0);
    end

    // Back-to-back sprites, the second one closing the line.
    out_cyc.delete(); d0 = ld_cnt;
    push_job(0, 1, 'h100);
    drive_job(0, 1, 'h100, 1'b0, 1'b0);
    push_job(64, 1, 'h101);
    drive_job(64, 1, 'h101, 1'b1, 1'b0);
    dmid = ld_cnt;
    wait_idle();
    chk("b2b_outputs", 64'(out_cyc.size()), 2);
    if (out_cyc.size() == 2) chk("b2b_zero_gap", 64'(out_cyc[1] - out_cyc[0] >= 2), 1);
    chk("b2b_no_early_done", 64'(dmid - d0), 0);
    chk("b2b_line_done", 64'(ld_cnt - d0), 1);
    mon_en = 1'b0;

    // line_start on the third request of an eight-group sprite.
    d0 = ld_cnt; bad = 0;
    drive_job(0, 8, 'h400, 1'b1, 1'b0);
    @(posedge clk_draw); #1;
    @(posedge clk_draw); #1;
    line_start = 1'b1;
    @(negedge clk_draw);
    chk("abort_ready_low", 64'(spr_ready), 0);
    @(posedge clk_draw); #1;
    line_start = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk_draw);
      if (k == 0) chk("abort_busy", 64'(busy), 0);
      if (k == 1) chk("abort_idle_ready", 64'(spr_ready), 1);
      if (tile_valid_mask != 4'h0) bad++;
    end
    chk("abort_discard", 64'(bad), 0);
    chk("abort_no_line_done", 64'(ld_cnt - d0), 0);

`ifdef SPRITE_HFLIP_EN
    drive_job(0, 2, 'h10, 1'b0, 1'b1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk_draw);
      if (k == 0) chk("hflip_addr0", 64'(mem_addr), 64'h11);
      if (k == 1) chk("hflip_addr1", 64'(mem_addr), 64'h10);
      if (k == 3) chk("hflip_pixels", 64'(tile_pixels), 64'h01020304);
      if (k == 3) chk("hflip_x", 64'(tile_x), 0);
    end
    wait_idle();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
